// File: rtl/rock_control_if.sv
// Signal bundle between the stress monitor, the rocking controller and the cradle motor driver.
// The master side drives the evaluation inputs; the slave side is the controller.
interface rock_control_if;
    logic       clk4;
    logic       enable;
    logic       gedaald;
    logic       gelijk;
    logic       error;
    logic [3:0] level;
    logic [1:0] state;
    logic       settled;
    logic       fault;
    logic       motor_step;
    logic       motor_dir;

    modport master (
        output clk4, enable, gedaald, gelijk, error,
        input  level, state, settled, fault, motor_step, motor_dir
    );

    modport slave (
        input  clk4, enable, gedaald, gelijk, error,
        output level, state, settled, fault, motor_step, motor_dir
    );
endinterface

// File: rtl/rock_control.sv
// Hill-climbing cradle rocking controller: adjusts the rocking level from stress-monitor flags
// on each evaluation strobe and drives the motor with step pulses and a swing-direction bit.
module rock_control #(
    parameter int MAX_LVL         = 15,
    parameter int START_LVL       = 4,
    parameter int BASE_PERIOD     = 1000,
    parameter int STEPS_PER_SWING = 8,
    parameter int ERR_LIMIT       = 3,
    parameter int SETTLE_TICKS    = 4
) (
    input logic          clk,
    input logic          reset,
    rock_control_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        HOLD   = 2'd2,
        FAULT  = 2'd3
    } state_t;

    // Widths are derived from the parameters so the period counter fits the slowest level.
    localparam int PW = $clog2(BASE_PERIOD * (MAX_LVL + 1) + 1);
    localparam int SW = (STEPS_PER_SWING > 1) ? $clog2(STEPS_PER_SWING) : 1;
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam int CW = $clog2(SETTLE_TICKS + 1);

    localparam logic [3:0]    MAX_L   = 4'(MAX_LVL);
    localparam logic [3:0]    START_L = 4'(START_LVL);
    localparam logic [EW-1:0] ERR_L   = EW'(ERR_LIMIT);
    localparam logic [CW-1:0] CALM_L  = CW'(SETTLE_TICKS);
    localparam logic [SW-1:0] SWING_L = SW'(STEPS_PER_SWING - 1);

    state_t        state_q, state_d;
    logic [3:0]    level_q, level_d;
    logic          dir_up, dir_d;
    logic [EW-1:0] err_cnt, err_d;
    logic [CW-1:0] calm_cnt, calm_d;
    logic          settled_q, fault_q;
    logic [PW-1:0] period_cnt;
    logic [SW-1:0] step_cnt;
    logic          step_q, mdir_q;

    function automatic logic [PW-1:0] period_of(input logic [3:0] lvl);
        return PW'(BASE_PERIOD * (MAX_LVL + 1 - int'(lvl)) - 1);
    endfunction

    // Level never drops below 1 while rocking; 0 is reserved for motor off.
    function automatic logic [3:0] step_level(input logic [3:0] lvl, input logic up);
        if (up)
            return (lvl >= MAX_L) ? MAX_L : lvl + 4'd1;
        else
            return (lvl <= 4'd1) ? 4'd1 : lvl - 4'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            level_q   <= 4'd0;
            dir_up    <= 1'b1;
            err_cnt   <= '0;
            calm_cnt  <= '0;
            settled_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            dir_up    <= dir_d;
            err_cnt   <= err_d;
            calm_cnt  <= calm_d;
            settled_q <= (state_d == HOLD);
            fault_q   <= (state_d == FAULT);
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        dir_d   = dir_up;
        err_d   = err_cnt;
        calm_d  = calm_cnt;
        case (state_q)
            IDLE: begin
                level_d = 4'd0;
                err_d   = '0;
                calm_d  = '0;
                if (bus.clk4 && bus.enable) begin
                    state_d = SEARCH;
                    level_d = START_L;
                    dir_d   = 1'b1;
                end
            end
            SEARCH, HOLD: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    level_d = 4'd0;
                    err_d   = '0;
                    calm_d  = '0;
                end else if (bus.clk4) begin
                    if (bus.error) begin
                        calm_d = '0;
                        if (err_cnt + EW'(1) >= ERR_L) begin
                            state_d = FAULT;
                            level_d = 4'd0;
                            err_d   = '0;
                        end else begin
                            err_d = err_cnt + EW'(1);
                        end
                    end else begin
                        err_d = '0;
                        if (bus.gedaald) begin
                            calm_d = '0;
                            if (state_q == SEARCH)
                                level_d = step_level(level_q, dir_up);
                        end else if (bus.gelijk) begin
                            if (state_q == SEARCH) begin
                                if (calm_cnt + CW'(1) >= CALM_L) begin
                                    state_d = HOLD;
                                    calm_d  = '0;
                                end else begin
                                    calm_d = calm_cnt + CW'(1);
                                end
                            end
                        end else begin
                            // Stress rose: in SEARCH reverse the climb, in HOLD back off downward.
                            calm_d = '0;
                            if (state_q == SEARCH) begin
                                dir_d   = !dir_up;
                                level_d = step_level(level_q, !dir_up);
                            end else begin
                                state_d = SEARCH;
                                dir_d   = 1'b0;
                                level_d = step_level(level_q, 1'b0);
                            end
                        end
                    end
                end
            end
            FAULT: begin
                level_d = 4'd0;
                err_d   = '0;
                calm_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Motor stops on the same edge the level goes to 0, so no stray step escapes a shutdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= period_of(START_L);
            step_cnt   <= '0;
            step_q     <= 1'b0;
            mdir_q     <= 1'b0;
        end else if (level_q == 4'd0 || level_d == 4'd0) begin
            period_cnt <= period_of(level_d);
            step_cnt   <= '0;
            step_q     <= 1'b0;
        end else if (period_cnt == '0) begin
            period_cnt <= period_of(level_q);
            step_q     <= 1'b1;
            if (step_cnt == SWING_L) begin
                step_cnt <= '0;
                mdir_q   <= !mdir_q;
            end else begin
                step_cnt <= step_cnt + SW'(1);
            end
        end else begin
            period_cnt <= period_cnt - PW'(1);
            step_q     <= 1'b0;
        end
    end

    assign bus.level      = level_q;
    assign bus.state      = state_q;
    assign bus.settled    = settled_q;
    assign bus.fault      = fault_q;
    assign bus.motor_step = step_q;
    assign bus.motor_dir  = mdir_q;

endmodule

// File: tb/tb_rock_control.sv
// Scoreboard bench for rock_control: evaluation responses are queued by the stimulus and
// checked by an independent monitor one clk after each strobe; motor timing is checked directly.
module tb_rock_control;

    typedef struct {
        logic [1:0] state;
        logic [3:0] level;
        string      name;
    } exp_t;

    logic clk;
    logic reset;
    logic expect_now;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    exp_t mon_e;

    rock_control_if bus();

    rock_control #(
        .MAX_LVL(15), .START_LVL(4), .BASE_PERIOD(4),
        .STEPS_PER_SWING(2), .ERR_LIMIT(3), .SETTLE_TICKS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: outputs are registered, so they reflect a strobe or reset just after that edge.
    always @(posedge clk) begin
        if (bus.clk4 || expect_now) begin
            #1;
            if (sb.size() == 0) begin
                checkOutput("scoreboard underflow", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput({mon_e.name, " state"}, int'(bus.state), int'(mon_e.state));
                checkOutput({mon_e.name, " level"}, int'(bus.level), int'(mon_e.level));
                checkOutput({mon_e.name, " settled"}, int'(bus.settled), int'(mon_e.state == 2'd2));
                checkOutput({mon_e.name, " fault"}, int'(bus.fault), int'(mon_e.state == 2'd3));
            end
        end
    end

    task automatic pushExp(input logic [1:0] st, input logic [3:0] lvl, input string name);
        exp_t e;
        e.state = st;
        e.level = lvl;
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic en, input logic ged, input logic gel, input logic err,
                                 input logic [1:0] exp_state, input logic [3:0] exp_level,
                                 input string name);
        @(negedge clk);
        bus.enable  = en;
        bus.gedaald = ged;
        bus.gelijk  = gel;
        bus.error   = err;
        bus.clk4    = 1'b1;
        pushExp(exp_state, exp_level, name);
        @(negedge clk);
        bus.clk4    = 1'b0;
        bus.gedaald = 1'b0;
        bus.gelijk  = 1'b0;
        bus.error   = 1'b0;
    endtask

    task automatic applyReset(input string name);
        @(negedge clk);
        reset      = 1'b1;
        expect_now = 1'b1;
        pushExp(2'd0, 4'd0, name);
        @(negedge clk);
        reset      = 1'b0;
        expect_now = 1'b0;
    endtask

    task automatic dropEnable(input string name);
        @(negedge clk);
        bus.enable = 1'b0;
        expect_now = 1'b1;
        pushExp(2'd0, 4'd0, name);
        @(negedge clk);
        expect_now = 1'b0;
    endtask

    task automatic measureStep(input int expected, input string name);
        int cycles = 0;
        bit found = 0;
        while (!found && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.motor_step) found = 1;
        end
        checkOutput(name, cycles, expected);
    endtask

    task automatic watchSteps(input int n, input int expected, input string name);
        int cnt = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.motor_step) cnt++;
        end
        checkOutput(name, cnt, expected);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        expect_now  = 1'b0;
        bus.clk4    = 1'b0;
        bus.enable  = 1'b0;
        bus.gedaald = 1'b0;
        bus.gelijk  = 1'b0;
        bus.error   = 1'b0;
        @(negedge clk);
        applyReset("reset");
        checkOutput("reset motor_step", int'(bus.motor_step), 0);
        checkOutput("reset motor_dir", int'(bus.motor_dir), 0);

        $display("[TB] start rocking and motor timing");
        applyStimulus(1, 0, 0, 0, 2'd1, 4'd4, "start");
        measureStep(48, "first step delay");
        @(posedge clk);
        #1;
        checkOutput("step pulse width", int'(bus.motor_step), 0);
        measureStep(47, "second step period");
        checkOutput("dir after 2 steps", int'(bus.motor_dir), 1);
        measureStep(48, "third step period");
        measureStep(48, "fourth step period");
        checkOutput("dir after 4 steps", int'(bus.motor_dir), 0);

        $display("[TB] hill climbing");
        applyStimulus(1, 1, 0, 0, 2'd1, 4'd5, "gedaald up");
        applyStimulus(1, 0, 0, 0, 2'd1, 4'd4, "rise reverses");
        applyStimulus(1, 1, 1, 0, 2'd1, 4'd3, "gedaald+gelijk down");

        $display("[TB] saturation");
        applyStimulus(1, 0, 0, 0, 2'd1, 4'd4, "reverse to up");
        for (int l = 5; l <= 15; l++)
            applyStimulus(1, 1, 0, 0, 2'd1, 4'(l), "climb");
        applyStimulus(1, 1, 0, 0, 2'd1, 4'd15, "saturate top");
        applyStimulus(1, 0, 0, 0, 2'd1, 4'd14, "reverse at top");
        for (int l = 13; l >= 1; l--)
            applyStimulus(1, 1, 0, 0, 2'd1, 4'(l), "descend");
        applyStimulus(1, 1, 0, 0, 2'd1, 4'd1, "saturate bottom");

        $display("[TB] settling");
        applyStimulus(1, 0, 0, 0, 2'd1, 4'd2, "reverse at bottom");
        applyStimulus(1, 0, 1, 0, 2'd1, 4'd2, "gelijk 1");
        applyStimulus(1, 0, 1, 0, 2'd1, 4'd2, "gelijk 2");
        applyStimulus(1, 1, 0, 0, 2'd1, 4'd3, "gedaald clears calm");
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 0, 1, 0, 2'd1, 4'd3, "gelijk run");
        applyStimulus(1, 0, 1, 0, 2'd2, 4'd3, "enter hold");
        applyStimulus(1, 1, 0, 0, 2'd2, 4'd3, "hold on gedaald");
        applyStimulus(1, 0, 0, 0, 2'd1, 4'd2, "leave hold");

        $display("[TB] errors and fault");
        applyStimulus(1, 0, 0, 1, 2'd1, 4'd2, "error 1");
        applyStimulus(1, 1, 0, 0, 2'd1, 4'd1, "gedaald clears errors");
        applyStimulus(1, 0, 0, 1, 2'd1, 4'd1, "error a");
        applyStimulus(1, 0, 0, 1, 2'd1, 4'd1, "error b");
        applyStimulus(1, 0, 0, 1, 2'd3, 4'd0, "error c faults");
        watchSteps(100, 0, "no steps in fault");
        applyStimulus(0, 0, 0, 0, 2'd3, 4'd0, "fault ignores disable");
        applyStimulus(1, 1, 0, 0, 2'd3, 4'd0, "fault ignores enable");
        applyReset("reset from fault");

        $display("[TB] disable and reset mid-period");
        applyStimulus(1, 0, 0, 0, 2'd1, 4'd4, "restart");
        applyStimulus(1, 1, 0, 0, 2'd1, 4'd5, "to 5");
        applyStimulus(1, 1, 0, 0, 2'd1, 4'd6, "to 6");
        repeat (20) @(negedge clk);
        dropEnable("enable drop");
        watchSteps(60, 0, "no steps after disable");
        applyStimulus(1, 0, 0, 0, 2'd1, 4'd4, "re-enable");
        measureStep(48, "step after re-enable");
        applyStimulus(1, 1, 0, 0, 2'd1, 4'd5, "again 5");
        applyStimulus(1, 1, 0, 0, 2'd1, 4'd6, "again 6");
        repeat (10) @(negedge clk);
        applyReset("reset mid-period");
        checkOutput("reset clears motor_dir", int'(bus.motor_dir), 0);
        watchSteps(60, 0, "no steps after reset");

        @(negedge clk);
        checkOutput("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
